// File: rtl/imm_split.sv
// imm_split: decomposes a 32-bit constant into the minimal sequence of
// 16-bit immediate beats, each tagged with the extender op that expands it.
`timescale 1ns/1ps

module imm_split (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_value,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_imm,
    output logic [1:0]  out_eop,
    output logic        out_last,
    output logic [31:0] beat_count
);

    localparam logic [1:0] EOP_SEXT = 2'b00;
    localparam logic [1:0] EOP_ZEXT = 2'b01;
    localparam logic [1:0] EOP_HIGH = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ONE  = 2'b01,
        HI   = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lo_q, lo_d;
    logic        valid_d;
    logic [15:0] imm_d;
    logic [1:0]  eop_d;
    logic        last_d;

    logic        accept;
    logic        out_hs;
    logic        v_sext;
    logic        v_hi_zero;
    logic        v_lo_zero;

    assign in_ready  = (state_q == IDLE) | ((state_q == ONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    assign v_sext    = (in_value == {{16{in_value[15]}}, in_value[15:0]});
    assign v_hi_zero = (in_value[31:16] == 16'h0000);
    assign v_lo_zero = (in_value[15:0] == 16'h0000);

    // Next-state and next-beat selection; an accept overrides the drain
    // decision of the current state because it only happens in IDLE or as
    // the final beat leaves.
    always_comb begin
        state_d = state_q;
        valid_d = out_valid;
        imm_d   = out_imm;
        eop_d   = out_eop;
        last_d  = out_last;
        lo_d    = lo_q;

        case (state_q)
            IDLE: ;
            ONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            HI: begin
                if (out_ready) begin
                    state_d = ONE;
                    imm_d   = lo_q;
                    eop_d   = EOP_ZEXT;
                    last_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (accept) begin
            valid_d = 1'b1;
            if (v_sext) begin
                state_d = ONE;
                imm_d   = in_value[15:0];
                eop_d   = EOP_SEXT;
                last_d  = 1'b1;
            end else if (v_hi_zero) begin
                state_d = ONE;
                imm_d   = in_value[15:0];
                eop_d   = EOP_ZEXT;
                last_d  = 1'b1;
            end else if (v_lo_zero) begin
                state_d = ONE;
                imm_d   = in_value[31:16];
                eop_d   = EOP_HIGH;
                last_d  = 1'b1;
            end else begin
                state_d = HI;
                imm_d   = in_value[31:16];
                eop_d   = EOP_HIGH;
                last_d  = 1'b0;
                lo_d    = in_value[15:0];
            end
        end
    end

    // State, pending low half and the registered output beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lo_q      <= '0;
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_eop   <= EOP_SEXT;
            out_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            out_valid <= valid_d;
            out_imm   <= imm_d;
            out_eop   <= eop_d;
            out_last  <= last_d;
        end
    end

    // Running count of output handshakes, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_count <= '0;
        end else if (out_hs) begin
            beat_count <= beat_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_imm_split.sv
// Directed and scoreboard bench for imm_split.
`timescale 1ns/1ps

module tb_imm_split;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_value;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [1:0]  out_eop;
    logic        out_last;
    logic [31:0] beat_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_bc   = 0;

    imm_split dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_value  (in_value),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_eop   (out_eop),
        .out_last  (out_last),
        .beat_count(beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned ref_beats(input logic [31:0] v);
        if (v == {{16{v[15]}}, v[15:0]} || v[31:16] == 16'h0 || v[15:0] == 16'h0)
            return 1;
        return 2;
    endfunction

    function automatic logic [31:0] gen_value();
        logic [15:0] r16;
        logic [31:0] edges [6];
        edges = '{32'h0000_7FFF, 32'h0000_8000, 32'hFFFF_7FFF,
                  32'h8000_0000, 32'h0001_0000, 32'hFFFF_0001};
        r16 = 16'($urandom);
        case ($urandom % 5)
            0: return {{16{r16[15]}}, r16};
            1: return {16'h0000, 1'b1, r16[14:0]};
            2: return {r16 | 16'h0001, 16'h0000};
            3: return $urandom;
            default: return edges[$urandom % 6];
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_value = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, out_imm, out_eop, out_last} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b imm=%h eop=%b last=%b, want all zero",
                     out_valid, out_imm, out_eop, out_last);
        end
        n_checks++;
        if (beat_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_count: got %h want 00000000", beat_count);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_classify();
        logic [31:0] cv [6];
        logic [18:0] ce [6];
        cv = '{32'h0000_1234, 32'hFFFF_8000, 32'h0000_8000,
               32'h1234_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        ce = '{{16'h1234, 2'b00, 1'b1}, {16'h8000, 2'b00, 1'b1}, {16'h8000, 2'b01, 1'b1},
               {16'h1234, 2'b10, 1'b1}, {16'hFFFF, 2'b00, 1'b1}, {16'h0000, 2'b00, 1'b1}};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_value = cv[i]; out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++;
            if ({out_valid, out_imm, out_eop, out_last} !== {1'b1, ce[i]}) begin
                n_fail++;
                $display("FAIL classify_%h: got v=%b imm=%h eop=%b last=%b, want v=1 imm=%h eop=%b last=%b",
                         cv[i], out_valid, out_imm, out_eop, out_last, ce[i][18:3], ce[i][2:1], ce[i][0]);
            end
        end
        @(negedge clk);
        exp_bc += 6;
        n_checks++;
        if (out_valid !== 1'b0 || beat_count !== exp_bc) begin
            n_fail++;
            $display("FAIL classify_count: got v=%b count=%0d, want v=0 count=%0d",
                     out_valid, beat_count, exp_bc);
        end
    endtask

    task automatic test_two_beat();
        @(negedge clk);
        in_valid = 1'b1; in_value = 32'h1234_5678; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_imm, out_eop, out_last} !== {1'b1, 16'h1234, 2'b10, 1'b0} || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL two_beat_hi: got v=%b imm=%h eop=%b last=%b rdy=%b, want 1 1234 10 0 rdy=0",
                     out_valid, out_imm, out_eop, out_last, in_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_imm, out_eop, out_last} !== {1'b1, 16'h5678, 2'b01, 1'b1}) begin
            n_fail++;
            $display("FAIL two_beat_lo: got v=%b imm=%h eop=%b last=%b, want 1 5678 01 1",
                     out_valid, out_imm, out_eop, out_last);
        end
        @(negedge clk);
        exp_bc += 2;
        n_checks++;
        if (out_valid !== 1'b0 || beat_count !== exp_bc) begin
            n_fail++;
            $display("FAIL two_beat_count: got v=%b count=%0d, want v=0 count=%0d",
                     out_valid, beat_count, exp_bc);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        in_valid = 1'b1; in_value = 32'hDEAD_BEEF; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if ({out_valid, out_imm, out_eop, out_last} !== {1'b1, 16'hDEAD, 2'b10, 1'b0} || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d: got v=%b imm=%h eop=%b last=%b rdy=%b, want 1 DEAD 10 0 rdy=0",
                         i, out_valid, out_imm, out_eop, out_last, in_ready);
            end
            in_value = 32'h0000_0001 << i;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_imm, out_eop, out_last} !== {1'b1, 16'hBEEF, 2'b01, 1'b1}) begin
            n_fail++;
            $display("FAIL backpressure_lo: got v=%b imm=%h eop=%b last=%b, want 1 BEEF 01 1",
                     out_valid, out_imm, out_eop, out_last);
        end
        @(negedge clk);
        exp_bc += 2;
        n_checks++;
        if (out_valid !== 1'b0 || beat_count !== exp_bc) begin
            n_fail++;
            $display("FAIL backpressure_count: got v=%b count=%0d, want v=0 count=%0d",
                     out_valid, beat_count, exp_bc);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] vals [3];
        logic [18:0] eb [4];
        int unsigned idx;
        logic        acc;
        vals = '{32'h0000_7FFF, 32'h0001_0001, 32'hABCD_0000};
        eb   = '{{16'h7FFF, 2'b00, 1'b1}, {16'h0001, 2'b10, 1'b0},
                 {16'h0001, 2'b01, 1'b1}, {16'hABCD, 2'b10, 1'b1}};
        idx = 0;
        @(negedge clk);
        in_valid = 1'b1; in_value = vals[0]; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            acc = in_valid & in_ready;
            @(negedge clk);
            if (acc) idx++;
            if (idx < 3) in_value = vals[idx];
            else         in_valid = 1'b0;
            n_checks++;
            if ({out_valid, out_imm, out_eop, out_last} !== {1'b1, eb[k]}) begin
                n_fail++;
                $display("FAIL stream_beat%0d: got v=%b imm=%h eop=%b last=%b, want v=1 imm=%h eop=%b last=%b",
                         k, out_valid, out_imm, out_eop, out_last, eb[k][18:3], eb[k][2:1], eb[k][0]);
            end
        end
        @(negedge clk);
        exp_bc += 4;
        n_checks++;
        if (out_valid !== 1'b0 || beat_count !== exp_bc) begin
            n_fail++;
            $display("FAIL stream_count: got v=%b count=%0d, want v=0 count=%0d",
                     out_valid, beat_count, exp_bc);
        end
    endtask

    task automatic test_reset_in_hi();
        @(negedge clk);
        in_valid = 1'b1; in_value = 32'h1234_5678; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_imm, out_eop, out_last} !== {1'b1, 16'h1234, 2'b10, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_hi_pre: got v=%b imm=%h eop=%b last=%b, want 1 1234 10 0",
                     out_valid, out_imm, out_eop, out_last);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_imm, out_eop, out_last} !== 20'h0 || beat_count !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_hi_async: got v=%b imm=%h eop=%b last=%b count=%0d, want all zero",
                     out_valid, out_imm, out_eop, out_last, beat_count);
        end
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hi_no_stale: got v=%b imm=%h, want v=0", out_valid, out_imm);
        end
        in_valid = 1'b1; in_value = 32'h0000_0005;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, out_imm, out_eop, out_last} !== {1'b1, 16'h0005, 2'b00, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_hi_after: got v=%b imm=%h eop=%b last=%b, want 1 0005 00 1",
                     out_valid, out_imm, out_eop, out_last);
        end
        @(negedge clk);
        exp_bc = 1;
        n_checks++;
        if (beat_count !== exp_bc) begin
            n_fail++;
            $display("FAIL rst_hi_count: got %0d want %0d", beat_count, exp_bc);
        end
    endtask

    task automatic test_scoreboard();
        logic [31:0] q [$];
        int unsigned sent, done, ref_total, cyc, beats_this;
        logic        pending, offering, acc, hs;
        logic [15:0] hi;
        logic [31:0] recon, exp_v;
        sent = 0; done = 0; ref_total = 0; cyc = 0; beats_this = 0;
        pending = 1'b0; offering = 1'b0; hi = '0;
        while (done < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom % 3) != 0;
            if (!offering) begin
                in_valid = 1'b0;
                if (sent < 1000 && ($urandom % 4) != 0) begin
                    in_value = gen_value();
                    in_valid = 1'b1;
                    offering = 1'b1;
                end
            end
            #1;
            acc = in_valid & in_ready;
            hs  = out_valid & out_ready;
            if (hs) begin
                beats_this++;
                if (!out_last) begin
                    pending = 1'b1;
                    hi      = out_imm;
                end else begin
                    case (out_eop)
                        2'b00:   recon = {{16{out_imm[15]}}, out_imm};
                        2'b01:   recon = {16'h0000, out_imm};
                        2'b10:   recon = {out_imm, 16'h0000};
                        default: recon = 'x;
                    endcase
                    if (pending) recon = {hi, 16'h0000} | recon;
                    n_checks++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_extra_beat: got recon=%h with no value outstanding, want none", recon);
                    end else begin
                        exp_v = q.pop_front();
                        if (recon !== exp_v || beats_this != ref_beats(exp_v)) begin
                            n_fail++;
                            $display("FAIL sb_value%0d: got recon=%h beats=%0d, want %h beats=%0d",
                                     done, recon, beats_this, exp_v, ref_beats(exp_v));
                        end
                    end
                    pending = 1'b0;
                    beats_this = 0;
                    done++;
                end
            end
            if (acc) begin
                q.push_back(in_value);
                ref_total += ref_beats(in_value);
                sent++;
                offering = 1'b0;
            end
        end
        n_checks++;
        if (done < 1000) begin
            n_fail++;
            $display("FAIL sb_timeout: got %0d values reconstructed, want 1000", done);
        end
        in_valid = 1'b0;
        @(negedge clk);
        exp_bc += ref_total;
        n_checks++;
        if (beat_count !== exp_bc) begin
            n_fail++;
            $display("FAIL sb_count: got %0d want %0d", beat_count, exp_bc);
        end
    endtask

    initial begin
        test_reset();
        test_classify();
        test_two_beat();
        test_backpressure();
        test_streaming();
        test_reset_in_hi();
        test_scoreboard();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_split.md
# imm_split

Constant decomposer for the MIPS datapath: accepts a 32-bit constant and emits the minimal sequence of 16-bit immediate beats. Each beat carries the extender operation code under which it must be expanded. It is the inverse of the immediate extender. Replaying the beats through the extender, with lui/ori semantics for two-beat results, must reproduce the original constant exactly. It sits between the constant-load/stimulus generator and the instruction emitter, with valid/ready handshakes on both sides.

## Interface
- No parameters; all widths fixed.
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  in_value is offered this cycle.
- in_value  input  32  constant to decompose.
- in_ready  output  1  block accepts in_value this cycle (combinational).
- out_valid  output  1  out_imm/out_eop/out_last hold a beat (registered).
- out_ready  input  1  consumer takes the beat this cycle.
- out_imm  output  16  immediate field of the beat.
- out_eop  output  2  extender op: 00 sign-extend, 01 zero-extend, 10 load-high (imm<<16); 11 never emitted.
- out_last  output  1  final beat of the current constant.
- beat_count  output  32  total beats handshaken since reset; wraps 0xFFFFFFFF -> 0.

## Operation
- Input accept: in_valid & in_ready. Output handshake: out_valid & out_ready.
- Accepted value V is classified once, at accept, in strict priority order:
  - V == sign-extend(V[15:0]) -> one beat: imm=V[15:0], eop=00, last=1.
  - else V[31:16]==0 -> one beat: imm=V[15:0], eop=01, last=1.
  - else V[15:0]==0 -> one beat: imm=V[31:16], eop=10, last=1.
  - else two beats: beat0 imm=V[31:16], eop=10, last=0; beat1 imm=V[15:0], eop=01, last=1.
- Two-beat mode latches V[15:0] in an internal register at accept.
- States:
  - IDLE: out_valid=0.
  - ONE: single or final beat presented.
  - HI: first of two beats presented.
- Transitions:
  - IDLE + accept -> ONE (single-beat class) or HI (two-beat class).
  - HI + output handshake -> ONE, presenting the low half (eop=01, last=1).
  - ONE + output handshake: -> IDLE with no accept; -> ONE/HI with a new value if accepted in the same cycle.
- in_ready = (state==IDLE) | (state==ONE & out_ready). A new constant may be accepted in the same cycle the last beat leaves. in_ready=0 in HI.
- While out_valid=1 and out_ready=0: out_imm, out_eop and out_last are held stable. The input is not accepted, and in_value changes are ignored.
- beat_count increments by 1 on each output handshake only.

## Timing
- Reset values: state IDLE, out_valid=0, out_imm=0x0000, out_eop=00, out_last=0, beat_count=0. in_ready=1 while reset is deasserted in IDLE.
- Reset asserted mid-sequence, including in HI, discards the pending low half. No partial beat appears after reset release.
- Latency: value accepted at edge N -> first beat valid after edge N, i.e. visible in cycle N+1.
- Throughput with out_ready held high: one beat per cycle, including back-to-back constants (single, single, two, single -> 5 beats in 5 consecutive cycles).
- in_valid asserted while in_ready=0: no accept, no state change. The producer must hold the value.
- out_ready has no effect while out_valid=0.
- Outputs out_valid/out_imm/out_eop/out_last are driven from flops only. in_ready is the only combinational output.

## Test plan
- Classification, out_ready=1: 0x00001234 -> {1234,00,1}; 0xFFFF8000 -> {8000,00,1}; 0x00008000 -> {8000,01,1}; 0x12340000 -> {1234,10,1}; 0xFFFFFFFF -> {FFFF,00,1}; 0x00000000 -> {0000,00,1}.
- Two-beat case: 0x12345678 -> {1234,10,0} then {5678,01,1} in consecutive cycles. in_ready=0 during the first beat. beat_count advances by 2.
- Backpressure: 0xDEADBEEF accepted, out_ready=0 for 3 cycles -> {DEAD,10,0} held unchanged. in_value toggled meanwhile is ignored. Release -> {BEEF,01,1}.
- Streaming: in_valid held with 0x7FFF, 0x00010001, 0xABCD0000, out_ready=1 -> beats {7FFF,00,1}, {0001,10,0}, {0001,01,1}, {ABCD,10,1} on 4 consecutive cycles, with no bubbles.
- Reset in HI: accept 0x12345678, assert reset while {1234,10,0} is presented -> all outputs at reset values immediately. After release, 0x00000005 -> {0005,00,1}, beat_count=1.
- Scoreboard, 1000 random values with random out_ready: expand the beats per the eop rules (two-beat result = (hi<<16)|lo). Every reconstruction must equal the input. Beat count must match the reference classification.
